// File: rtl/bcd_mod_counter.sv
// Packed-BCD modulo counter with preset, up/down direction and a cascadable
// carry/borrow. Counts MIN_VAL..TOP, where TOP is MOD-1 for a zero-based
// range and MOD for a one-based (12-hour style) range.
//
// Handshake note: there is no valid/ready pair here. EN is a one-cycle
// strobe that is consumed on the edge where it is high. cin is a
// combinational strobe meant to drive the EN of the next stage in the same
// cycle.
module bcd_mod_counter #(
  parameter int MOD     = 60,
  parameter int MIN_VAL = 0
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       adjust,
  input  logic       mode,
  input  logic       PE,
  input  logic [7:0] pre_val,
  output logic [7:0] show_val,
  output logic       cin,
  output logic       pe_err
);

  localparam int         TOP     = (MIN_VAL == 1) ? MOD : MOD - 1;
  localparam logic [7:0] TOP_BCD = 8'(((TOP / 10) * 16) + (TOP % 10));
  localparam logic [7:0] MIN_BCD = 8'(MIN_VAL);

  logic [7:0] show_val_q, show_val_d;
  logic       pe_err_q, pe_err_d;

  logic [7:0] pre_bin;
  logic       pre_ok;
  logic       at_top, at_min;
  logic [7:0] inc_val, dec_val;

  // Preset validation: both digits decimal and the value inside MIN_VAL..TOP.
  always_comb begin
    pre_bin = (8'(pre_val[7:4]) * 8'd10) + 8'(pre_val[3:0]);
    pre_ok  = (pre_val[7:4] <= 4'd9) && (pre_val[3:0] <= 4'd9) &&
              ((MIN_VAL == 0) || (pre_bin != 8'd0)) &&
              (pre_bin <= 8'(TOP));
  end

  // One-step BCD increment/decrement including the wrap at either end.
  always_comb begin
    at_top = (show_val_q == TOP_BCD);
    at_min = (show_val_q == MIN_BCD);
    if (at_top)
      inc_val = MIN_BCD;
    else if (show_val_q[3:0] == 4'd9)
      inc_val = {show_val_q[7:4] + 4'd1, 4'd0};
    else
      inc_val = {show_val_q[7:4], show_val_q[3:0] + 4'd1};
    if (at_min)
      dec_val = TOP_BCD;
    else if (show_val_q[3:0] == 4'd0)
      dec_val = {show_val_q[7:4] - 4'd1, 4'd9};
    else
      dec_val = {show_val_q[7:4], show_val_q[3:0] - 4'd1};
  end

  // Next-state selection: preset beats counting; a rejected preset holds.
  always_comb begin
    show_val_d = show_val_q;
    pe_err_d   = 1'b0;
    if (PE) begin
      if (pre_ok) show_val_d = pre_val;
      else        pe_err_d   = 1'b1;
    end else if (EN) begin
      show_val_d = mode ? dec_val : inc_val;
    end
  end

  // State registers with synchronous reset to the lowest count value.
  always_ff @(posedge CP) begin
    if (CR) begin
      show_val_q <= MIN_BCD;
      pe_err_q   <= 1'b0;
    end else begin
      show_val_q <= show_val_d;
      pe_err_q   <= pe_err_d;
    end
  end

  // Carry/borrow to the next stage, suppressed while setting the time.
  always_comb begin
    cin = EN & ~PE & ~CR & ~adjust & (mode ? at_min : at_top);
  end

  assign show_val = show_val_q;
  assign pe_err   = pe_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: a MOD=60 instance and a 12-hour instance share
// the same stimulus. A binary-arithmetic reference model predicts each edge;
// predictions go through an expected queue and are compared after the edge.
// A constant vector table and a few hand sequences pin the corner cases.
module tb_bcd_mod_counter;

  logic       CP = 1'b0;
  logic       CR = 1'b0, EN = 1'b0, adjust = 1'b0, mode = 1'b0, PE = 1'b0;
  logic [7:0] pre_val = 8'h00;
  logic [7:0] show60, show12;
  logic       cin60, cin12, err60, err12;

  bcd_mod_counter #(.MOD(60), .MIN_VAL(0)) dut60 (
    .CP(CP), .CR(CR), .EN(EN), .adjust(adjust), .mode(mode), .PE(PE),
    .pre_val(pre_val), .show_val(show60), .cin(cin60), .pe_err(err60));

  bcd_mod_counter #(.MOD(12), .MIN_VAL(1)) dut12 (
    .CP(CP), .CR(CR), .EN(EN), .adjust(adjust), .mode(mode), .PE(PE),
    .pre_val(pre_val), .show_val(show12), .cin(cin12), .pe_err(err12));

  // clock / watchdog
  always #5 CP = ~CP;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model (binary arithmetic, converted to BCD only for compare)
  int m60 = 0;
  int m12 = 1;
  logic [8:0] exp60_q[$];
  logic [8:0] exp12_q[$];
  logic last_cin60, last_cin12;

  function automatic logic [7:0] i2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic model_cin(input int v, input int mod, input int minv,
                                     input logic cr, pe, en, adj, md);
    int top;
    top = (minv == 1) ? mod : mod - 1;
    return en & ~pe & ~cr & ~adj & (md ? (v == minv) : (v == top));
  endfunction

  task automatic model_next(input int v, input int mod, input int minv,
                            input logic cr, pe, en, md, input logic [7:0] pre,
                            output int nv, output logic err);
    int top, pv;
    top = (minv == 1) ? mod : mod - 1;
    pv  = int'(pre[7:4]) * 10 + int'(pre[3:0]);
    nv  = v;
    err = 1'b0;
    if (cr) nv = minv;
    else if (pe) begin
      if (pre[7:4] <= 4'd9 && pre[3:0] <= 4'd9 && pv >= minv && pv <= top) nv = pv;
      else err = 1'b1;
    end else if (en) begin
      if (md) nv = (v == minv) ? top : v - 1;
      else    nv = (v == top)  ? minv : v + 1;
    end
  endtask

  // driver: one edge of stimulus, cin checked before it, state after it
  task automatic drive(input logic cr, pe, en, adj, md, input logic [7:0] pre);
    logic c60, c12, e60, e12;
    int   n60, n12;
    logic [8:0] x;
    @(negedge CP);
    CR = cr; PE = pe; EN = en; adjust = adj; mode = md; pre_val = pre;
    c60 = model_cin(m60, 60, 0, cr, pe, en, adj, md);
    c12 = model_cin(m12, 12, 1, cr, pe, en, adj, md);
    model_next(m60, 60, 0, cr, pe, en, md, pre, n60, e60);
    model_next(m12, 12, 1, cr, pe, en, md, pre, n12, e12);
    exp60_q.push_back({e60, i2bcd(n60)});
    exp12_q.push_back({e12, i2bcd(n12)});
    #1;
    last_cin60 = cin60;
    last_cin12 = cin12;
    check("cin60", {7'd0, cin60}, {7'd0, c60});
    check("cin12", {7'd0, cin12}, {7'd0, c12});
    @(posedge CP);
    #1;
    m60 = n60;
    m12 = n12;
    x = exp60_q.pop_front();
    check("show60", show60, x[7:0]);
    check("err60", {7'd0, err60}, {7'd0, x[8]});
    x = exp12_q.pop_front();
    check("show12", show12, x[7:0]);
    check("err12", {7'd0, err12}, {7'd0, x[8]});
  endtask

  // constant vector table for the MOD=60 instance
  typedef struct {
    logic       cr, pe, en, adj, md;
    logic [7:0] pre;
    logic [7:0] e_show;
    logic       e_cin;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cr, pe, en, adj, md, input logic [7:0] pre,
                              input logic [7:0] e_show, input logic e_cin, e_err);
    vec_t v;
    v.cr = cr; v.pe = pe; v.en = en; v.adj = adj; v.md = md; v.pre = pre;
    v.e_show = e_show; v.e_cin = e_cin; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    int cin_hits;
    //             cr pe en ad md pre     show   cin err
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0)); // reset
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0)); // first up step
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h45, 8'h45, 0, 0)); // valid preset
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h5A, 8'h45, 0, 1)); // non-BCD units
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h45, 0, 0)); // err clears
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h60, 8'h45, 0, 1)); // above TOP
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h59, 8'h59, 0, 0)); // preset TOP
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0)); // adjust wrap, no carry
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h59, 1, 0)); // down wrap, borrow
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h58, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h59, 8'h59, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0)); // up wrap, carry
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h37, 8'h37, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 8'h45, 8'h00, 0, 0)); // reset beats preset
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h37, 8'h37, 0, 0)); // preset beats step
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h38, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h09, 8'h09, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h10, 0, 0)); // units 9->0, tens+1
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h09, 0, 0)); // units 0->9, tens-1
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h08, 0, 0)); // adjust still steps
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'h59, 0, 0)); // adjust down wrap
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0)); // mode flip, no latency
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h99, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h9F, 8'h00, 0, 1)); // back-to-back reject
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h5A, 8'h00, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0)); // reset clears err

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cr, tbl[i].pe, tbl[i].en, tbl[i].adj, tbl[i].md, tbl[i].pre);
      check($sformatf("tbl%0d_show", i), show60, tbl[i].e_show);
      check($sformatf("tbl%0d_cin", i), {7'd0, last_cin60}, {7'd0, tbl[i].e_cin});
      check($sformatf("tbl%0d_err", i), {7'd0, err60}, {7'd0, tbl[i].e_err});
    end

    // full up cycle from reset: exactly one carry, on 59
    drive(1, 0, 0, 0, 0, 8'h00);
    cin_hits = 0;
    for (int i = 0; i < 60; i++) begin
      drive(0, 0, 1, 0, 0, 8'h00);
      if (last_cin60) cin_hits++;
    end
    check("up60_cin_hits", 8'(cin_hits), 8'd1);
    check("up60_end", show60, 8'h00);

    // down from reset: 00 -> 59 -> 58
    drive(1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 8'h00);
    check("down60_cin", {7'd0, last_cin60}, 8'd1);
    check("down60_a", show60, 8'h59);
    drive(0, 0, 1, 0, 1, 8'h00);
    check("down60_b", show60, 8'h58);

    // 12-hour instance: reset to 01, wrap 12->01 and 01->12 with carry
    drive(1, 0, 1, 0, 0, 8'h00);
    check("h12_reset", show12, 8'h01);
    drive(0, 1, 0, 0, 0, 8'h12);
    check("h12_preset", show12, 8'h12);
    drive(0, 0, 1, 0, 0, 8'h00);
    check("h12_up_cin", {7'd0, last_cin12}, 8'd1);
    check("h12_up_wrap", show12, 8'h01);
    drive(0, 0, 1, 0, 1, 8'h00);
    check("h12_dn_cin", {7'd0, last_cin12}, 8'd1);
    check("h12_dn_wrap", show12, 8'h12);
    drive(0, 1, 0, 0, 0, 8'h00);
    check("h12_rej00", {7'd0, err12}, 8'd1);
    check("h12_hold", show12, 8'h12);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] p;
      if ($urandom_range(0, 1) == 1) p = i2bcd(int'($urandom_range(0, 99)));
      else                           p = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, p);
    end

    check("queue60_empty", 8'(exp60_q.size()), 8'd0);
    check("queue12_empty", 8'(exp12_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter MOD, default 60, counter modulus: count range is MIN_VAL..MOD-1 when MIN_VAL=0, and MIN_VAL..MOD when MIN_VAL=1 (12-hour style); legal MOD is 2..99.
REQ-002 Parameter MIN_VAL, default 0, lowest count value; legal values are 0 or 1.
REQ-003 CP  input  1  system clock; all state updates on the rising edge.
REQ-004 CR  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  count tick, one CP cycle wide per step (e.g. 1 Hz strobe or upstream carry).
REQ-006 adjust  input  1  time-set mode: steps still occur on EN, but carry/borrow output is suppressed.
REQ-007 mode  input  1  direction: 0 = count up, 1 = count down.
REQ-008 PE  input  1  preset enable: load pre_val on this edge.
REQ-009 pre_val  input  8  preset value, packed BCD {tens[7:4], units[3:0]}.
REQ-010 show_val  output  8  current count, packed BCD, registered.
REQ-011 cin  output  1  carry (up) / borrow (down) to next stage, combinational.
REQ-012 pe_err  output  1  registered one-cycle flag: last preset was rejected.

Function
REQ-013 Top value TOP = MOD-1 if MIN_VAL=0, else MOD; wrap is TOP->MIN_VAL going up and MIN_VAL->TOP going down.
REQ-014 Per-edge priority: CR > PE > EN; exactly one action per edge.
REQ-015 PE=1 with valid pre_val (both nibbles <=9, MIN_VAL <= value <= TOP): show_val <= pre_val next edge, pe_err <= 0.
REQ-016 PE=1 with invalid pre_val: show_val holds, pe_err <= 1 for exactly one cycle.
REQ-017 PE=0, EN=1, mode=0: show_val increments by one in BCD (units 9->0 with tens+1); TOP wraps to MIN_VAL.
REQ-018 PE=0, EN=1, mode=1: show_val decrements by one in BCD (units 0->9 with tens-1); MIN_VAL wraps to TOP.
REQ-019 PE=0, EN=0: show_val holds; pe_err <= 0 on any edge without a rejected preset.
REQ-020 cin = EN & ~PE & ~CR & ~adjust & (mode ? show_val==MIN_VAL : show_val==TOP); asserted in the same cycle as the wrapping edge so the next stage can use cin as its EN.
REQ-021 The adjust input only gates cin; step direction and wrap are unchanged under adjust.
REQ-022 show_val never leaves MIN_VAL..TOP and never holds a non-BCD nibble, for any input sequence.
REQ-023 mode may change on any cycle; it takes effect at the next EN edge with no extra latency.
REQ-024 Latency: input to show_val is one CP edge; input to cin is zero cycles; input to pe_err is one edge.

Reset
REQ-025 CR=1 on a rising edge: show_val <= MIN_VAL in BCD, pe_err <= 0, regardless of PE/EN/mode.
REQ-026 While CR=1, cin = 0.
REQ-027 CR asserted mid-count or together with PE: reset wins; the first step after release uses the reset value.

Verification
REQ-028 MOD=60, MIN_VAL=0, up, EN every cycle from reset: 00,01..09,10..59,00; cin=1 only during the cycle show_val=59.
REQ-029 MOD=60, down from reset: 00->59->58; cin=1 during the cycle show_val=00 with EN=1.
REQ-030 MOD=12, MIN_VAL=1: reset -> 01; up steps 12->01 with cin; down steps 01->12 with cin.
REQ-031 PE with pre_val=8'h5A or 8'h60 (MOD=60): show_val unchanged, pe_err=1 for one cycle; PE with 8'h45: show_val=45, pe_err=0.
REQ-032 adjust=1, show_val=59, EN=1, up: show_val -> 00 and cin stays 0.
REQ-033 Same edge CR=1, PE=1, EN=1, show_val=37: show_val -> 00 and cin=0; same edge PE=1, EN=1: preset wins with no increment.
